// File: rtl/cfg_bank_pkg.sv
// ---------------------------------------------------------------------------
// cfg_bank_pkg
// Shared definitions for the bl/wl memory-bank frame writer:
//   - state_t     : writer FSM states
//   - calc_wpf    : number of input words needed to fill one frame
//   - cnt_width   : counter width helper that never returns zero
//   - crc8_bit    : one-bit step of the CRC-8 (poly 0x07, MSB-first register)
//   - CRC8_POLY / CRC8_INIT
// ---------------------------------------------------------------------------
package cfg_bank_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WRITE = 3'd2,
    HOLD  = 3'd3,
    CRC   = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  // Words per frame: ceil(num_bl / din_width).
  function automatic int calc_wpf(input int num_bl, input int din_width);
    return (num_bl + din_width - 1) / din_width;
  endfunction

  // Width of a counter holding 0..n-1, at least one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Shift one data bit into the CRC register.
  function automatic logic [7:0] crc8_bit(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/cfg_frame_packer.sv
// ---------------------------------------------------------------------------
// cfg_frame_packer
// Assembles DIN_WIDTH-bit words into one NUM_BL-bit frame. Word k bit j lands
// in frame[k*DIN_WIDTH + j]; bits that would fall beyond NUM_BL are dropped.
// Ports:
//   clk, srst    clock and synchronous active-high reset
//   clear        zero the frame and the word counter (start of a pass)
//   en           words may be taken this cycle (writer is loading)
//   in_valid     in_data is valid
//   in_data      bitstream word
//   load_done    strobe: the last word of the frame is transferring now
//   word_cnt     index of the word that the next transfer fills
//   frame        assembled frame register
// ---------------------------------------------------------------------------
module cfg_frame_packer
  import cfg_bank_pkg::*;
#(
  parameter int NUM_BL    = 70,
  parameter int DIN_WIDTH = 8,
  localparam int WPF      = calc_wpf(NUM_BL, DIN_WIDTH),
  localparam int CW       = cnt_width(WPF)
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 clear,
  input  logic                 en,
  input  logic                 in_valid,
  input  logic [DIN_WIDTH-1:0] in_data,
  output logic                 load_done,
  output logic [CW-1:0]        word_cnt,
  output logic [0:NUM_BL-1]    frame
);

  logic [CW-1:0]     cnt_reg;
  logic [CW-1:0]     cnt_next;
  logic [0:NUM_BL-1] frame_reg;
  logic [0:NUM_BL-1] frame_next;
  logic              xfer;

  assign xfer      = en & in_valid;
  assign load_done = xfer && (cnt_reg == CW'(WPF - 1));

  // The counter wraps to zero on the final word so the next frame starts clean.
  always_comb begin
    cnt_next = cnt_reg;
    if (clear || load_done) begin
      cnt_next = '0;
    end else if (xfer) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  // Each frame bit only listens to the one word slot that owns it, so pad
  // bits of the last word simply have no destination.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_BL; gi++) begin : g_bit
      assign frame_next[gi] = clear ? 1'b0 :
                              (xfer && (cnt_reg == CW'(gi / DIN_WIDTH))) ? in_data[gi % DIN_WIDTH] :
                              frame_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_reg   <= '0;
      frame_reg <= '0;
    end else begin
      cnt_reg   <= cnt_next;
      frame_reg <= frame_next;
    end
  end

  assign word_cnt = cnt_reg;
  assign frame    = frame_reg;

endmodule

// File: rtl/cfg_bank_frame_writer.sv
// ---------------------------------------------------------------------------
// cfg_bank_frame_writer
// Programming-side driver for a bl/wl memory-bank configuration interface.
// Packs the incoming bitstream into NUM_BL-bit frames and writes each frame by
// driving it on bl while pulsing one word line for WL_PULSE cycles, followed
// by a one-cycle hold, sweeping wl[0] .. wl[NUM_WL-1].
//
// Optional feature, macro CFG_BANK_FRAME_WRITER_CRC_EN: a CRC-8 over all frame
// bits is checked against one trailing word and reported on crc_err.
//
// Ports:
//   prog_clk    configuration clock
//   prog_reset  synchronous active-high reset
//   start       begins a pass when idle
//   in_data     bitstream word, in_valid/in_ready handshake
//   bl          bit-line drive
//   wl          word-line drive, at most one bit high
//   busy        pass in progress
//   done        pass completed, held until the next accepted start
//   crc_err     (CRC build only) trailing CRC did not match
// ---------------------------------------------------------------------------
module cfg_bank_frame_writer
  import cfg_bank_pkg::*;
#(
  parameter int NUM_BL    = 70,
  parameter int NUM_WL    = 70,
  parameter int DIN_WIDTH = 8,
  parameter int WL_PULSE  = 2
) (
  input  logic                 prog_clk,
  input  logic                 prog_reset,
  input  logic                 start,
  input  logic [DIN_WIDTH-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [0:NUM_BL-1]    bl,
  output logic [0:NUM_WL-1]    wl,
  output logic                 busy,
  output logic                 done
`ifdef CFG_BANK_FRAME_WRITER_CRC_EN
  ,
  output logic                 crc_err
`endif
);

  localparam int WPF = calc_wpf(NUM_BL, DIN_WIDTH);
  localparam int CW  = cnt_width(WPF);
  localparam int RW  = cnt_width(NUM_WL);
  localparam int PW  = cnt_width(WL_PULSE);

  state_t            state_reg;
  state_t            state_next;
  logic [RW-1:0]     row_reg;
  logic [PW-1:0]     pulse_reg;
  logic [0:NUM_BL-1] bl_reg;
  logic              done_reg;

  logic              start_acc;
  logic              last_row;
  logic              load_done;
  logic [CW-1:0]     word_cnt;
  logic [0:NUM_BL-1] frame;

  assign start_acc = (state_reg == IDLE) && start;
  assign last_row  = (row_reg == RW'(NUM_WL - 1));

  cfg_frame_packer #(
    .NUM_BL    (NUM_BL),
    .DIN_WIDTH (DIN_WIDTH)
  ) u_packer (
    .clk       (prog_clk),
    .srst      (prog_reset),
    .clear     (start_acc),
    .en        (state_reg == LOAD),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .load_done (load_done),
    .word_cnt  (word_cnt),
    .frame     (frame)
  );

  // ---------------- state register ----------------
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (start) state_next = LOAD;
      LOAD:  if (load_done) state_next = WRITE;
      WRITE: if (pulse_reg == PW'(WL_PULSE - 1)) state_next = HOLD;
      HOLD: begin
        if (last_row) begin
`ifdef CFG_BANK_FRAME_WRITER_CRC_EN
          state_next = CRC;
`else
          state_next = DONE;
`endif
        end else begin
          state_next = LOAD;
        end
      end
      CRC:   if (in_valid) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- output logic ----------------
  always_comb begin
    in_ready = (state_reg == LOAD) || (state_reg == CRC);
    busy     = (state_reg == LOAD) || (state_reg == WRITE) ||
               (state_reg == HOLD) || (state_reg == CRC);
    wl       = '0;
    if (state_reg == WRITE) begin
      wl[row_reg] = 1'b1;
    end
    // The live frame is shown only while writing/holding; during the next
    // LOAD the packer is being overwritten, so bl falls back to the copy.
    bl   = ((state_reg == WRITE) || (state_reg == HOLD)) ? frame : bl_reg;
    done = done_reg;
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      row_reg   <= '0;
      pulse_reg <= '0;
      bl_reg    <= '0;
      done_reg  <= 1'b0;
    end else begin
      if (start_acc) begin
        row_reg <= '0;
      end else if ((state_reg == HOLD) && !last_row) begin
        row_reg <= row_reg + 1'b1;
      end

      if (state_reg == WRITE) begin
        pulse_reg <= pulse_reg + 1'b1;
      end else begin
        pulse_reg <= '0;
      end

      if (state_next == DONE) begin
        bl_reg <= '0;
      end else if (state_reg == WRITE) begin
        bl_reg <= frame;
      end

      if (start_acc) begin
        done_reg <= 1'b0;
      end else if (state_next == DONE) begin
        done_reg <= 1'b1;
      end
    end
  end

`ifdef CFG_BANK_FRAME_WRITER_CRC_EN
  logic [7:0] crc_reg;
  logic [7:0] crc_word;
  logic       crc_err_reg;

  // Fold the accepted word into the CRC, bit 0 first, skipping pad bits.
  always_comb begin
    crc_word = crc_reg;
    for (int j = 0; j < DIN_WIDTH; j++) begin
      if ((int'(word_cnt) * DIN_WIDTH + j) < NUM_BL) begin
        crc_word = crc8_bit(crc_word, in_data[j]);
      end
    end
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      crc_reg     <= CRC8_INIT;
      crc_err_reg <= 1'b0;
    end else if (start_acc) begin
      crc_reg     <= CRC8_INIT;
      crc_err_reg <= 1'b0;
    end else if ((state_reg == LOAD) && in_valid) begin
      crc_reg <= crc_word;
    end else if ((state_reg == CRC) && in_valid) begin
      crc_err_reg <= (in_data[7:0] != crc_reg);
    end
  end

  assign crc_err = crc_err_reg;
`else
  logic unused_word_cnt;
  assign unused_word_cnt = ^word_cnt;
`endif

endmodule

// File: tb/tb_cfg_bank_frame_writer.sv
`timescale 1ns/1ps
// Bench for cfg_bank_frame_writer: random and patterned bitstreams, checked
// against a frame/CRC model built directly from the word list.
module tb_cfg_bank_frame_writer;

  localparam int NUM_BL    = 70;
  localparam int NUM_WL    = 70;
  localparam int DIN_WIDTH = 8;
  localparam int WL_PULSE  = 2;
  localparam int WPF       = (NUM_BL + DIN_WIDTH - 1) / DIN_WIDTH;
  localparam int NWORDS    = NUM_WL * WPF;
`ifdef CFG_BANK_FRAME_WRITER_CRC_EN
  localparam int NTOTAL    = NWORDS + 1;
  localparam int CRC_EXTRA = 1;
`else
  localparam int NTOTAL    = NWORDS;
  localparam int CRC_EXTRA = 0;
`endif
  localparam int EXP_LAT   = NUM_WL * (WPF + WL_PULSE + 1) + CRC_EXTRA;

  logic                 prog_clk = 1'b0;
  logic                 prog_reset;
  logic                 start;
  logic [DIN_WIDTH-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [0:NUM_BL-1]    bl;
  logic [0:NUM_WL-1]    wl;
  logic                 busy;
  logic                 done;
`ifdef CFG_BANK_FRAME_WRITER_CRC_EN
  logic                 crc_err;
  logic [7:0]           crc_flip;
`endif

  int total_cnt = 0;
  int bad_cnt   = 0;

  logic [DIN_WIDTH-1:0] words   [0:NWORDS];
  logic [0:NUM_BL-1]    seen_bl [0:NUM_WL-1];

  always #5 prog_clk = ~prog_clk;

  cfg_bank_frame_writer #(
    .NUM_BL    (NUM_BL),
    .NUM_WL    (NUM_WL),
    .DIN_WIDTH (DIN_WIDTH),
    .WL_PULSE  (WL_PULSE)
  ) dut (
    .prog_clk   (prog_clk),
    .prog_reset (prog_reset),
    .start      (start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .bl         (bl),
    .wl         (wl),
    .busy       (busy),
    .done       (done)
`ifdef CFG_BANK_FRAME_WRITER_CRC_EN
    ,
    .crc_err    (crc_err)
`endif
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected frame for row r straight from the word list.
  function automatic logic [0:NUM_BL-1] exp_frame(input int r);
    logic [0:NUM_BL-1]    f;
    logic [DIN_WIDTH-1:0] w;
    for (int b = 0; b < NUM_BL; b++) begin
      w    = words[r * WPF + b / DIN_WIDTH];
      f[b] = w[b % DIN_WIDTH];
    end
    return f;
  endfunction

`ifdef CFG_BANK_FRAME_WRITER_CRC_EN
  function automatic logic [7:0] model_crc();
    logic [7:0] c;
    logic       fb;
    logic [0:NUM_BL-1] f;
    c = 8'h00;
    for (int r = 0; r < NUM_WL; r++) begin
      f = exp_frame(r);
      for (int b = 0; b < NUM_BL; b++) begin
        fb = c[7] ^ f[b];
        c  = {c[6:0], 1'b0};
        if (fb) c = c ^ 8'h07;
      end
    end
    return c;
  endfunction
`endif

  // kind 0: all 0xA5, 1: random, 2: random with pad-test frame 0
  task automatic fill_words(input int kind);
    for (int i = 0; i < NWORDS; i++) begin
      words[i] = (kind == 0) ? 8'hA5 : DIN_WIDTH'($urandom);
    end
    if (kind == 2) begin
      for (int i = 0; i < WPF - 1; i++) words[i] = '0;
      words[WPF - 1] = 8'hFF;
    end
`ifdef CFG_BANK_FRAME_WRITER_CRC_EN
    words[NWORDS] = model_crc() ^ crc_flip;
`else
    words[NWORDS] = '0;
`endif
  endtask

  // mode 0: back-to-back, 1: valid toggles, 2: random valid plus stray starts
  task automatic run_pass(input string name, input int mode, input int abort_row);
    int   i, cyc, first_acc, done_cyc, rows_seen, plen, cur, idx, n, viol;
    bit   acc, done_seen, aborted;
    logic [0:NUM_BL-1] bl_at_done;
    logic busy_at_done;
    i = 0; cyc = 0; first_acc = -1; done_cyc = -1; rows_seen = 0;
    plen = 0; cur = -1; viol = 0; done_seen = 0; aborted = 0;
    bl_at_done = '0; busy_at_done = 1'b0;

    @(posedge prog_clk); #1;
    start = 1'b1;
    @(posedge prog_clk); #1;
    start = 1'b0;
    check_eq({name, "_done_clr"}, done, 0);
    check_eq({name, "_busy"}, busy, 1);

    while (!done_seen && !aborted && cyc < 6000) begin
      if (i < NTOTAL) begin
        case (mode)
          0:       in_valid = 1'b1;
          1:       in_valid = (cyc % 2 == 0);
          default: in_valid = ($urandom_range(0, 3) != 0);
        endcase
        in_data = words[i];
        start   = (mode == 2) && ($urandom_range(0, 15) == 0);
      end else begin
        in_valid = 1'b0;
        in_data  = DIN_WIDTH'($urandom);
        start    = 1'b0;
      end

      @(negedge prog_clk);
      acc = in_valid && in_ready;
      if (acc && first_acc < 0) first_acc = cyc;
      n = $countones(wl);
      if (n > 1) viol++;
      if (n == 1) begin
        idx = 0;
        for (int k = 0; k < NUM_WL; k++) if (wl[k]) idx = k;
        if (idx != cur) begin
          if (plen != 0) viol++;
          check_eq({name, "_wl_row"}, idx, rows_seen);
          check_eq({name, "_bl_frame"}, bl, exp_frame(idx));
          seen_bl[idx] = bl;
          cur = idx; plen = 0; rows_seen++;
        end
        plen++;
        if (idx == abort_row) begin
          prog_reset = 1'b1;
          in_valid   = 1'b0;
          start      = 1'b0;
          @(posedge prog_clk); #1;
          prog_reset = 1'b0;
          @(negedge prog_clk);
          check_eq({name, "_rst_wl"}, wl, 0);
          check_eq({name, "_rst_bl"}, bl, 0);
          check_eq({name, "_rst_busy"}, busy, 0);
          check_eq({name, "_rst_ready"}, in_ready, 0);
          check_eq({name, "_rst_done"}, done, 0);
          aborted = 1;
        end
      end else if (plen != 0) begin
        check_eq({name, "_wl_pulse"}, plen, WL_PULSE);
        plen = 0; cur = -1;
      end
      if (done && !aborted) begin
        done_seen    = 1;
        done_cyc     = cyc;
        bl_at_done   = bl;
        busy_at_done = busy;
        if (wl != '0) viol++;
      end
      if (!aborted) begin
        @(posedge prog_clk); #1;
        if (acc) i++;
        cyc++;
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;

    if (aborted) begin
      $display("pass %s aborted at row %0d after %0d rows", name, abort_row, rows_seen);
      return;
    end
    check_eq({name, "_finished"}, done_seen, 1);
    check_eq({name, "_rows"}, rows_seen, NUM_WL);
    check_eq({name, "_wl_rules"}, viol, 0);
    check_eq({name, "_words"}, i, NTOTAL);
    check_eq({name, "_bl_done"}, bl_at_done, 0);
    check_eq({name, "_busy_done"}, busy_at_done, 0);
    if (mode == 0) check_eq({name, "_latency"}, done_cyc - first_acc, EXP_LAT);
`ifdef CFG_BANK_FRAME_WRITER_CRC_EN
    check_eq({name, "_crc_err"}, crc_err, (crc_flip != 0));
`endif
    $display("pass %s mode=%0d rows=%0d words=%0d cycles=%0d", name, mode, rows_seen, i, cyc);
  endtask

  initial begin
    int chg;
    prog_reset = 1'b1;
    start      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
`ifdef CFG_BANK_FRAME_WRITER_CRC_EN
    crc_flip   = 8'h00;
`endif
    repeat (3) @(posedge prog_clk);
    #1 prog_reset = 1'b0;
    @(negedge prog_clk);
    check_eq("reset_bl", bl, 0);
    check_eq("reset_wl", wl, 0);
    check_eq("reset_ready", in_ready, 0);
    check_eq("reset_done", done, 0);
    check_eq("reset_busy", busy, 0);
`ifdef CFG_BANK_FRAME_WRITER_CRC_EN
    check_eq("reset_crc_err", crc_err, 0);
`endif

    chg = 0;
    repeat (20) begin
      @(negedge prog_clk);
      if (bl != '0 || wl != '0 || in_ready || done || busy) chg++;
    end
    check_eq("idle_stable", chg, 0);
    $display("reset/idle: 20 cycles observed");

    fill_words(0);
    run_pass("a5_b2b", 0, -1);
    repeat (5) @(negedge prog_clk);
    check_eq("done_hold", done, 1);
    check_eq("idle_busy", busy, 0);

    run_pass("a5_toggle", 1, -1);

    fill_words(2);
    run_pass("pad_rand", 2, -1);
    check_eq("pad_low", seen_bl[0][0:63], 0);
    check_eq("pad_high", seen_bl[0][64:69], 6'h3F);

    fill_words(1);
    run_pass("abort", 0, 5);

    fill_words(1);
    run_pass("after_abort", 0, -1);

`ifdef CFG_BANK_FRAME_WRITER_CRC_EN
    crc_flip = 8'h01;
    fill_words(1);
    run_pass("crc_bad", 2, -1);
    crc_flip = 8'h00;
`endif

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
